// File: rtl/tx_skp_scheduler_if.sv
// Symbol-stream interface between the TX ordered-set mux, the SKP scheduler and the 8b/10b encoder.
// The master drives the upstream symbol stream and tx_enable; the slave returns ready and the encoder feed.
interface tx_skp_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_enable;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_datak;
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_datak;
  logic                  skp_sent;
  logic                  skp_overrun;

  modport master (
    output tx_enable, in_data, in_datak, in_valid, in_sop,
    input  in_ready, out_data, out_datak, skp_sent, skp_overrun
  );

  modport slave (
    input  tx_enable, in_data, in_datak, in_valid, in_sop,
    output in_ready, out_data, out_datak, skp_sent, skp_overrun
  );
endinterface

// File: rtl/tx_skp_scheduler.sv
// TX clock-compensation source: schedules one SKP ordered set (COM + SKP_COUNT x SKP) per SKP_INTERVAL
// symbols and inserts it only at a packet boundary. Define SKP_PENDING_ACC_EN for a multi-request queue.
module tx_skp_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3,
  parameter int PEND_WIDTH   = 2
) (
  input logic               clk,
  input logic               rst_n,
  tx_skp_scheduler_if.slave bus
);

  localparam int                    CNT_W    = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [2:0]            IDX_LAST = 3'(SKP_COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] SYM_COM  = DATA_WIDTH'(8'hBC);
  localparam logic [DATA_WIDTH-1:0] SYM_SKP  = DATA_WIDTH'(8'h1C);
  localparam logic [DATA_WIDTH-1:0] SYM_IDLE = '0;

`ifdef SKP_PENDING_ACC_EN
  localparam int PW = PEND_WIDTH;
`else
  localparam int PW = 1;
`endif
  localparam logic [PW-1:0] PEND_MAX = '1;

  if (SKP_COUNT < 1 || SKP_COUNT > 7 || SKP_INTERVAL < SKP_COUNT + 2 || PEND_WIDTH < 1) begin : g_param_check
    $error("tx_skp_scheduler: illegal parameter combination");
  end

  typedef enum logic {ST_PASS, ST_SKP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    pending;
  logic [2:0]       idx;

  logic expire;
  logic start;
  logic done;
  logic pend_full;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    expire    = bus.tx_enable && (cnt == CNT_LAST);
    start     = (state == ST_PASS) && bus.tx_enable && (pending != '0) &&
                (!bus.in_valid || bus.in_sop);
    done      = (state == ST_SKP) && (idx == IDX_LAST);
    pend_full = (pending == PEND_MAX);
  end

  assign bus.in_ready = (state == ST_PASS) && !start;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_PASS;
      cnt             <= '0;
      pending         <= '0;
      idx             <= '0;
      bus.out_data    <= SYM_IDLE;
      bus.out_datak   <= 1'b0;
      bus.skp_sent    <= 1'b0;
      bus.skp_overrun <= 1'b0;
    end else begin
      if (!bus.tx_enable || cnt == CNT_LAST) cnt <= '0;
      else                                   cnt <= cnt + 1'b1;

      // An ordered set in flight keeps its request until it completes, even after disable.
      if (!bus.tx_enable && (state == ST_PASS || done)) pending <= '0;
      else if (expire && !done && !pend_full)            pending <= pending + 1'b1;
      else if (done && !expire)                          pending <= pending - 1'b1;

      bus.skp_overrun <= expire && pend_full && !done;
      bus.skp_sent    <= 1'b0;

      case (state)
        ST_PASS: begin
          if (start) begin
            bus.out_data  <= SYM_COM;
            bus.out_datak <= 1'b1;
            idx           <= '0;
            state         <= ST_SKP;
          end else if (bus.in_valid) begin
            bus.out_data  <= bus.in_data;
            bus.out_datak <= bus.in_datak;
          end else begin
            bus.out_data  <= SYM_IDLE;
            bus.out_datak <= 1'b0;
          end
        end
        ST_SKP: begin
          bus.out_data  <= SYM_SKP;
          bus.out_datak <= 1'b1;
          if (done) begin
            bus.skp_sent <= 1'b1;
            state        <= ST_PASS;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// Self-checking bench for tx_skp_scheduler with SKP_INTERVAL=16, SKP_COUNT=3: vector tables for the
// idle and boundary streams, a passthrough scoreboard, and hand sequences for overrun, disable and reset.
module tb_tx_skp_scheduler;

  localparam int INTERVAL = 16;

  typedef struct {
    logic       valid;
    logic       sop;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_k;
    logic [7:0] exp_data;
    logic       exp_sent;
    logic       exp_ovr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  tx_skp_scheduler_if #(.DATA_WIDTH(8)) bus ();

  tx_skp_scheduler #(
    .DATA_WIDTH  (8),
    .SKP_INTERVAL(INTERVAL),
    .SKP_COUNT   (3),
    .PEND_WIDTH  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  vec_t       vecs[64];
  logic [8:0] exp_q[$];

  int   edge_n, com_cnt, sent_cnt, ovr_cnt, data_cnt, nready_cnt;
  int   last_com_edge, last_data_edge, last_ovr_edge;
  logic pre_ready, accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    edge_n = -1; com_cnt = 0; sent_cnt = 0; ovr_cnt = 0; data_cnt = 0; nready_cnt = 0;
    last_com_edge = -1; last_data_edge = -1; last_ovr_edge = -1;
    exp_q.delete();
  endtask

  // One clock: sample handshake before the edge, outputs 1 time unit after it.
  task automatic step();
    logic [8:0] exp;
    #2;
    pre_ready = bus.in_ready;
    accepted  = bus.in_valid && bus.in_ready;
    if (!pre_ready) nready_cnt++;
    if (accepted) exp_q.push_back({bus.in_datak, bus.in_data});
    @(posedge clk);
    #1;
    edge_n++;
    if (rst_n) begin
      if (bus.out_datak && bus.out_data == 8'hBC) begin com_cnt++; last_com_edge = edge_n; end
      if (bus.skp_sent) sent_cnt++;
      if (bus.skp_overrun) begin ovr_cnt++; last_ovr_edge = edge_n; end
      if (!bus.out_datak && bus.out_data != 8'h00) begin
        data_cnt++;
        last_data_edge = edge_n;
        if (exp_q.size() == 0) begin
          check($sformatf("sb_underflow@%0d", edge_n), {23'b0, bus.out_datak, bus.out_data}, 32'h1ff);
        end else begin
          exp = exp_q.pop_front();
          check($sformatf("sb_data@%0d", edge_n), {23'b0, bus.out_datak, bus.out_data}, {23'b0, exp});
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.tx_enable = 1'b0; bus.in_valid = 1'b0; bus.in_sop = 1'b0;
    bus.in_data = 8'h00; bus.in_datak = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    clear_stats();
  endtask

  task automatic send_packet(input int n, input logic [7:0] base);
    int i;
    int budget;
    i = 0;
    budget = n + 64;
    while (i < n && budget > 0) begin
      bus.in_valid = 1'b1; bus.in_sop = (i == 0); bus.in_data = base + 8'(i); bus.in_datak = 1'b0;
      step();
      if (accepted) i++;
      budget--;
    end
    bus.in_valid = 1'b0; bus.in_sop = 1'b0;
    if (i < n) check("pkt_timeout", i, n);
  endtask

  task automatic run_table(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = vecs[i].valid; bus.in_sop = vecs[i].sop;
      bus.in_data = vecs[i].data;   bus.in_datak = 1'b0;
      step();
      check($sformatf("%s_ready[%0d]", tag, i), 32'(pre_ready), 32'(vecs[i].exp_ready));
      check($sformatf("%s_out[%0d]", tag, i),
            32'({bus.skp_overrun, bus.skp_sent, bus.out_datak, bus.out_data}),
            32'({vecs[i].exp_ovr, vecs[i].exp_sent, vecs[i].exp_k, vecs[i].exp_data}));
    end
    bus.in_valid = 1'b0; bus.in_sop = 1'b0;
  endtask

  task automatic wait_com(input int budget, output int found);
    int start_cnt;
    start_cnt = com_cnt;
    found = -1;
    for (int i = 0; i < budget && found < 0; i++) begin
      step();
      if (com_cnt != start_cnt) found = edge_n;
    end
  endtask

  initial begin
    int base, found, ph;
    bus.tx_enable = 1'b0; bus.in_valid = 1'b0; bus.in_sop = 1'b0;
    bus.in_data = 8'h00; bus.in_datak = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out", 32'({bus.skp_overrun, bus.skp_sent, bus.out_datak, bus.out_data}), 32'h0);
    check("rst_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #1;

    // Idle stream: COM at 16, SKPs at 17..19, repeating every interval.
    apply_reset();
    bus.tx_enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ph = c % INTERVAL;
      vecs[c] = '{valid:1'b0, sop:1'b0, data:8'h00, exp_ready:1'b1, exp_k:1'b0,
                  exp_data:8'h00, exp_sent:1'b0, exp_ovr:1'b0};
      if (c >= INTERVAL && ph <= 3) begin
        vecs[c].exp_ready = 1'b0;
        vecs[c].exp_k     = 1'b1;
        vecs[c].exp_data  = (ph == 0) ? 8'hBC : 8'h1C;
        vecs[c].exp_sent  = (ph == 3);
      end
    end
    run_table(40, "idle");

    // Expiry mid-packet: the set waits for the end of the packet.
    apply_reset();
    bus.tx_enable = 1'b1;
    repeat (5) step();
    send_packet(20, 8'h20);
    while (edge_n < 30) step();
    check("mid_com_edge", last_com_edge, 25);
    check("mid_last_data", last_data_edge, 24);
    check("mid_data_cnt", data_cnt, 20);
    check("mid_sb_empty", exp_q.size(), 0);
    check("mid_nready", nready_cnt, 4);
    check("mid_sent_cnt", sent_cnt, 1);

    // Boundary hit: a held SOP symbol follows the ordered set unchanged.
    apply_reset();
    bus.tx_enable = 1'b1;
    for (int c = 0; c < 22; c++)
      vecs[c] = '{valid:1'b0, sop:1'b0, data:8'h00, exp_ready:1'b1, exp_k:1'b0,
                  exp_data:8'h00, exp_sent:1'b0, exp_ovr:1'b0};
    for (int c = 16; c <= 20; c++) begin
      vecs[c].valid = 1'b1; vecs[c].sop = 1'b1; vecs[c].data = 8'h5A;
    end
    for (int c = 16; c <= 19; c++) begin
      vecs[c].exp_ready = 1'b0;
      vecs[c].exp_k     = 1'b1;
      vecs[c].exp_data  = (c == 16) ? 8'hBC : 8'h1C;
    end
    vecs[19].exp_sent = 1'b1;
    vecs[20].exp_data = 8'h5A;
    run_table(22, "bnd");
    check("bnd_sb_empty", exp_q.size(), 0);

    // Two expiries inside one long packet.
    apply_reset();
    bus.tx_enable = 1'b1;
    send_packet(40, 8'h60);
    while (edge_n < 47) step();
    check("ovr_data_cnt", data_cnt, 40);
    check("ovr_sb_empty", exp_q.size(), 0);
`ifdef SKP_PENDING_ACC_EN
    check("ovr_pulses", ovr_cnt, 0);
    check("ovr_com_cnt", com_cnt, 2);
    check("ovr_second_com", last_com_edge, 44);
    check("ovr_sent_cnt", sent_cnt, 2);
    check("ovr_nready", nready_cnt, 8);
`else
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_pulse_edge", last_ovr_edge, 31);
    check("ovr_com_cnt", com_cnt, 1);
    check("ovr_com_edge", last_com_edge, 40);
    check("ovr_sent_cnt", sent_cnt, 1);
    check("ovr_nready", nready_cnt, 4);
`endif

    // Disable on the COM cycle: the set still completes, then nothing more while disabled.
    apply_reset();
    bus.tx_enable = 1'b1;
    while (edge_n < 16) step();
    check("dis_com_edge", last_com_edge, 16);
    bus.tx_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("dis_skp[%0d]", k), 32'({bus.skp_sent, bus.out_datak, bus.out_data}),
            32'({(k == 2), 1'b1, 8'h1C}));
    end
    send_packet(5, 8'hA0);
    repeat (30) step();
    check("dis_com_cnt", com_cnt, 1);
    check("dis_sent_cnt", sent_cnt, 1);
    check("dis_data_cnt", data_cnt, 5);
    check("dis_nready", nready_cnt, 4);
    bus.tx_enable = 1'b1;
    base = edge_n + 1;
    wait_com(40, found);
    check("dis_reenable_com", found - base, INTERVAL);

    // Async reset during the second SKP.
    apply_reset();
    bus.tx_enable = 1'b1;
    while (edge_n < 18) step();
    check("rst_pre_out", 32'({bus.out_datak, bus.out_data}), 32'h11C);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", 32'({bus.skp_overrun, bus.skp_sent, bus.out_datak, bus.out_data}), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_hold[%0d]", k), 32'({bus.skp_sent, bus.out_datak, bus.out_data}), 32'h0);
    end
    rst_n = 1'b1;
    clear_stats();
    base = edge_n + 1;
    wait_com(40, found);
    check("rst_first_com", found - base, INTERVAL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
